// File: rtl/quad_enc_decoder.sv
// x4 quadrature decoder: modulo rotor position, direction, windowed signed speed,
// index capture and a sticky illegal-transition flag for the vector-control core.
//
// state    | meaning
// ST_PRIME | first edge after reset: capture channel history, no events
// ST_RUN   | decoding steps, index edges and illegal transitions
module quad_enc_decoder #(
  parameter int POS_W   = 16,
  parameter int LINES   = 1024,
  parameter int WIN_CYC = 10000,
  parameter int SPD_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    chn_a,
  input  logic                    chn_b,
  input  logic                    chn_z,
  input  logic                    zero_en,
  input  logic                    err_clr,
  output logic [POS_W-1:0]        pos,
  output logic                    dir,
  output logic signed [SPD_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    index_seen,
  output logic                    err
);

  localparam int CNT_W = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(4 * LINES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic signed [SPD_W:0] SUM_MAX = {2'b00, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W:0] SUM_MIN = {2'b11, {(SPD_W-2){1'b0}}, 1'b1};

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]              prev_ab;
  logic                    prev_z;
  logic [CNT_W-1:0]        win_cnt;
  logic signed [SPD_W-1:0] acc;

  logic [1:0]              cur_ab;
  logic                    run;
  logic                    step_fwd;
  logic                    step_rev;
  logic                    illegal;
  logic                    index_rise;
  logic                    win_end;
  logic [POS_W-1:0]        pos_step;
  logic signed [SPD_W:0]   step_val;
  logic signed [SPD_W:0]   acc_sum;
  logic signed [SPD_W-1:0] acc_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_PRIME: state_d = ST_RUN;
      ST_RUN:   run     = 1'b1;
      default:  state_d = ST_PRIME;
    endcase
  end

  assign cur_ab = {chn_a, chn_b};

  // Gray sequence 00->01->11->10 is forward; single-bit moves against it are reverse.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    illegal  = 1'b0;
    if (run) begin
      case ({prev_ab, cur_ab})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: step_rev = 1'b1;
        default:                            illegal  = &(prev_ab ^ cur_ab);
      endcase
    end
  end

  assign index_rise = run & chn_z & ~prev_z;
  assign win_end    = (win_cnt == CNT_LAST);

  always_comb begin
    pos_step = pos;
    if (step_fwd) begin
      pos_step = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end else if (step_rev) begin
      pos_step = (pos == '0) ? POS_LAST : pos - POS_W'(1);
    end
  end

  // One extra bit of headroom so the clamp sees the true sum before truncation.
  always_comb begin
    step_val = '0;
    if (step_fwd) begin
      step_val = (SPD_W+1)'(1);
    end else if (step_rev) begin
      step_val = -(SPD_W+1)'(1);
    end
    acc_sum = {acc[SPD_W-1], acc} + step_val;
    acc_sat = acc_sum[SPD_W-1:0];
    if (acc_sum > SUM_MAX) begin
      acc_sat = SUM_MAX[SPD_W-1:0];
    end else if (acc_sum < SUM_MIN) begin
      acc_sat = SUM_MIN[SPD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab    <= 2'b00;
      prev_z     <= 1'b0;
      pos        <= '0;
      dir        <= 1'b0;
      err        <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      prev_z  <= chn_z;
      if (index_rise && zero_en) begin
        pos <= '0;
      end else begin
        pos <= pos_step;
      end
      if (step_fwd) begin
        dir <= 1'b1;
      end else if (step_rev) begin
        dir <= 1'b0;
      end
      if (illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (index_rise) begin
        index_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= win_end;
      if (win_end) begin
        win_cnt <= '0;
        acc     <= '0;
        speed   <= acc_sat;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        acc     <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder with LINES=1024 and a 100-cycle speed window.
module tb_quad_enc_decoder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               chn_a, chn_b, chn_z, zero_en, err_clr;
  logic [15:0]        pos;
  logic               dir;
  logic signed [15:0] speed;
  logic               speed_valid, index_seen, err;

  int checks   = 0;
  int failures = 0;
  int e        = 0;
  int idx      = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_enc_decoder #(
    .POS_W  (16),
    .LINES  (1024),
    .WIN_CYC(100),
    .SPD_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chn_a      (chn_a),
    .chn_b      (chn_b),
    .chn_z      (chn_z),
    .zero_en    (zero_en),
    .err_clr    (err_clr),
    .pos        (pos),
    .dir        (dir),
    .speed      (speed),
    .speed_valid(speed_valid),
    .index_seen (index_seen),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic apply();
    chn_a = seq[idx][1];
    chn_b = seq[idx][0];
  endtask

  task automatic step_fwd();
    idx = (idx + 1) % 4;
    apply();
  endtask

  task automatic step_rev();
    idx = (idx + 3) % 4;
    apply();
  endtask

  task automatic step_ill();
    idx = (idx + 2) % 4;
    apply();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; idx = 0; apply();
    chn_z = 1'b0; zero_en = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_pos", {16'b0, pos}, 32'd0);
    chk("rst_dir", {31'b0, dir}, 32'd0);
    chk("rst_speed", {16'b0, speed}, 32'd0);
    chk("rst_valid", {31'b0, speed_valid}, 32'd0);
    chk("rst_index", {31'b0, index_seen}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    @(negedge clk); rst_n = 1'b1;
    tick(1);
    chk("prime_pos", {16'b0, pos}, 32'd0);

    // reverse wrap then forward back to zero
    step_rev(); tick(1);
    chk("wrap_rev_pos", {16'b0, pos}, 32'd4095);
    chk("wrap_rev_dir", {31'b0, dir}, 32'd0);
    step_fwd(); tick(1);
    chk("wrap_fwd_pos", {16'b0, pos}, 32'd0);
    chk("wrap_fwd_dir", {31'b0, dir}, 32'd1);

    for (int i = 1; i <= 8; i++) begin
      step_fwd(); tick(4);
      chk("fwd_pos", {16'b0, pos}, 32'(i));
      chk("fwd_dir", {31'b0, dir}, 32'd1);
      chk("fwd_err", {31'b0, err}, 32'd0);
    end

    // illegal transitions and err_clr priority
    step_ill(); tick(1);
    chk("ill_pos", {16'b0, pos}, 32'd8);
    chk("ill_err", {31'b0, err}, 32'd1);
    err_clr = 1'b1; step_ill(); tick(1);
    chk("ill_clr_err", {31'b0, err}, 32'd1);
    chk("ill_clr_pos", {16'b0, pos}, 32'd8);
    tick(1);
    chk("clr_err", {31'b0, err}, 32'd0);
    err_clr = 1'b0;

    // index with zero_en
    for (int i = 0; i < 30; i++) begin
      step_fwd(); tick(1);
    end
    step_rev(); tick(1);
    chk("pre_idx_pos", {16'b0, pos}, 32'd37);
    chk("pre_idx_dir", {31'b0, dir}, 32'd0);
    chk("pre_idx_seen", {31'b0, index_seen}, 32'd0);
    zero_en = 1'b1; chn_z = 1'b1; step_fwd(); tick(1);
    chk("idx_zero_pos", {16'b0, pos}, 32'd0);
    chk("idx_zero_seen", {31'b0, index_seen}, 32'd1);
    chk("idx_zero_dir", {31'b0, dir}, 32'd1);
    zero_en = 1'b0; chn_z = 1'b0; tick(1);
    for (int i = 0; i < 37; i++) begin
      step_fwd(); tick(1);
    end
    chk("pre_idx2_pos", {16'b0, pos}, 32'd37);
    chn_z = 1'b1; step_fwd(); tick(1);
    chk("idx_nozero_pos", {16'b0, pos}, 32'd38);
    chk("idx_nozero_seen", {31'b0, index_seen}, 32'd1);
    chn_z = 1'b0;

    // asynchronous reset mid-run
    for (int i = 0; i < 462; i++) begin
      step_fwd(); tick(1);
    end
    chk("pre_rst_pos", {16'b0, pos}, 32'd500);
    step_ill(); tick(1);
    chk("pre_rst_err", {31'b0, err}, 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("arst_pos", {16'b0, pos}, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    chk("arst_dir", {31'b0, dir}, 32'd0);
    chk("arst_index", {31'b0, index_seen}, 32'd0);
    chk("arst_valid", {31'b0, speed_valid}, 32'd0);
    idx = 2; apply();
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    chk("reprime_pos", {16'b0, pos}, 32'd0);
    chk("reprime_err", {31'b0, err}, 32'd0);
    tick(2);
    chk("reprime_hold", {16'b0, pos}, 32'd0);
    step_fwd(); tick(1);
    chk("reprime_step_pos", {16'b0, pos}, 32'd1);
    chk("reprime_step_err", {31'b0, err}, 32'd0);

    // speed windows aligned to a fresh release
    rst_n = 1'b0; idx = 0; apply(); #3;
    @(negedge clk); rst_n = 1'b1; e = 0;
    tick(1);
    for (int i = 0; i < 25; i++) begin
      step_fwd(); tick(2);
    end
    tick(99 - e);
    chk("win1_pre_valid", {31'b0, speed_valid}, 32'd0);
    tick(1);
    chk("win1_valid", {31'b0, speed_valid}, 32'd1);
    chk("win1_speed", {16'b0, speed}, 32'd25);
    tick(1);
    chk("win1_post_valid", {31'b0, speed_valid}, 32'd0);
    chk("win1_hold_speed", {16'b0, speed}, 32'd25);
    for (int i = 0; i < 10; i++) begin
      step_rev(); tick(2);
    end
    tick(200 - e);
    chk("win2_valid", {31'b0, speed_valid}, 32'd1);
    chk("win2_speed", {16'b0, speed}, 32'h0000_FFF6);
    tick(299 - e);
    step_fwd(); tick(1);
    chk("win3_valid", {31'b0, speed_valid}, 32'd1);
    chk("win3_last_step", {16'b0, speed}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_enc_decoder.md
Name: quad_enc_decoder

Overview:
- Quadrature decoder that sits directly downstream of the per-channel encoder input filters.
- Consumes the debounced A, B and Z encoder channels and performs x4 decoding into a modulo rotor position counter.
- Also provides direction, windowed signed speed (counts per window) and a sticky illegal-transition flag, all to the vector-control core.

Parameters:
- POS_W, 16: position counter width; 4*LINES must be <= 2^POS_W.
- LINES, 1024: encoder lines per revolution; position wraps at 4*LINES counts.
- WIN_CYC, 10000: speed measurement window length in clk cycles; must be >= 2.
- SPD_W, 16: signed speed output width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chn_a  in  1  filtered channel A, synchronous to clk.
- chn_b  in  1  filtered channel B, synchronous to clk.
- chn_z  in  1  filtered index channel, synchronous to clk.
- zero_en  in  1  when 1, an index rising edge zeroes pos.
- err_clr  in  1  clears err.
- pos  out  POS_W  rotor position in counts, 0..4*LINES-1.
- dir  out  1  direction of last valid step; 1 = forward, 0 = reverse.
- speed  out  SPD_W  signed count of steps in the last complete window.
- speed_valid  out  1  one-cycle strobe when speed updates.
- index_seen  out  1  sticky; set on the first index rising edge.
- err  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pos=0, dir=0, speed=0, speed_valid=0, index_seen=0, err=0.
  - Window counter=0, accumulator=0, primed=0, prev_ab=00, prev_z=0.
- Priming:
  - First clk edge after reset release: load prev_ab={chn_a,chn_b} and prev_z=chn_z, set primed=1.
  - No step, error or index event is generated on this edge.
- Step decode, every edge while primed: compare cur={chn_a,chn_b} with prev_ab, then prev_ab<=cur.
  - Forward (+1): 00->01, 01->11, 11->10, 10->00.
  - Reverse (-1): 00->10, 10->11, 11->01, 01->00.
  - cur==prev_ab: no step.
  - Both bits changed: illegal; no step, err<=1.
- Latency: pos, dir and err reflect a channel change on the same clk edge that first samples it (one register stage).
- Position wrap:
  - +1 at 4*LINES-1 gives 0.
  - -1 at 0 gives 4*LINES-1.
- dir updates on every valid step and holds otherwise.
- Index:
  - Rising edge = chn_z=1 with prev_z=0.
  - On a rising edge, index_seen<=1.
  - If zero_en=1 at that edge, pos<=0; this overrides any step in the same cycle. The step still counts toward speed and still updates dir.
- err:
  - Sticky; err_clr=1 clears it.
  - Illegal transition in the same cycle as err_clr: err=1 (set wins).
- Speed window:
  - Window counter counts 0..WIN_CYC-1, free-running from reset release.
  - Signed accumulator adds each step (+1/-1), saturating at +/-(2^(SPD_W-1)-1).
  - At the edge where the counter is WIN_CYC-1:
    - speed <= saturated (accumulator + this cycle's step).
    - Accumulator <= 0, counter <= 0.
    - speed_valid=1 for exactly that cycle; 0 otherwise.
  - First valid strobe occurs WIN_CYC cycles after reset release.
- Reset asserted mid-operation: all state returns to reset values immediately; priming repeats after release.

Test Plan:
- Forward run: after priming, drive AB 00,01,11,10,00,01,11,10, one state per 4 clks -> pos steps 0..8, dir=1, err=0.
- Reverse wrap: from pos=0, AB 00->10 -> pos=4095 (LINES=1024), dir=0; then 10->00 -> pos=4096 wraps to 0? No: 10->00 is forward, so pos=0, dir=1.
- Illegal: AB 00->11 -> pos unchanged, err=1. Assert err_clr together with a second illegal 11->00 -> err stays 1. err_clr alone -> err=0.
- Index: pos=37, zero_en=1, chn_z 0->1 with a forward step in the same cycle -> pos=0, index_seen=1, dir=1. Repeat with zero_en=0 -> pos=38, index_seen stays 1.
- Speed: WIN_CYC=100, 25 forward steps in window 1 -> speed=25 with a 1-cycle speed_valid at cycle 100 after release. 10 reverse steps in window 2 -> speed=-10.
- Reset mid-run: pull rst_n low with pos=500 and err=1 -> all outputs 0 asynchronously. After release, the first edge primes with no count even if AB differs from 00.
